// File: rtl/slice_serial_alu.sv
// Bit-serial 74381-style ALU: one SLICE-bit slice per clock, LSB first.
// Slice carry lives in a register; results publish only on the last slice.
module slice_serial_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  input  logic             c_in,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       s_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] f_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             done_q;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] x_sl;
  logic [SLICE-1:0] y_sl;
  logic [SLICE-1:0] f_sl;
  logic [SLICE:0]   sum;
  logic             arith;
  logic             c_msb;
  logic             last;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
  end

  assign arith = (s_q == 3'b001) || (s_q == 3'b010) || (s_q == 3'b011);

  always_comb begin
    x_sl = a_sl;
    y_sl = b_sl;
    unique case (1'b1)
      (s_q == 3'b001): x_sl = ~a_sl;
      (s_q == 3'b010): y_sl = ~b_sl;
      default: ;
    endcase
  end

  assign sum = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE{1'b0}}, carry_q};

  // Carry into the slice MSB, recovered from the sum bit and its operands.
  assign c_msb = sum[SLICE-1] ^ x_sl[SLICE-1] ^ y_sl[SLICE-1];

  always_comb begin
    f_sl = '0;
    unique case (s_q)
      3'b000: f_sl = '0;
      3'b001: f_sl = sum[SLICE-1:0];
      3'b010: f_sl = sum[SLICE-1:0];
      3'b011: f_sl = sum[SLICE-1:0];
      3'b100: f_sl = a_sl ^ b_sl;
      3'b101: f_sl = a_sl | b_sl;
      3'b110: f_sl = a_sl & b_sl;
      3'b111: f_sl = '1;
      default: f_sl = '0;
    endcase
  end

  always_comb begin
    res_d = res_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IW'(i)) begin
        res_d[i*SLICE +: SLICE] = f_sl;
      end
    end
  end

  assign carry_d = arith & sum[SLICE];
  assign last    = (idx_q == IW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            carry_q <= c_in;
            idx_q   <= '0;
            res_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            f_q     <= res_d;
            cout_q  <= carry_d;
            ovf_q   <= arith & (c_msb ^ sum[SLICE]);
            zero_q  <= (res_d == '0);
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f        = f_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_slice_serial_alu.sv
// Scoreboard bench: three ALU builds (32/4, 32/32, 16/4) against an
// arithmetic reference model; a monitor checks done timing, results, holds.
module tb_slice_serial_alu;

  typedef struct {
    logic [31:0] f;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_x = '0;
  logic [31:0] a_r = '0;
  logic [31:0] b_r = '0;
  logic [2:0]  s_r = '0;
  logic        cin_r = 1'b0;

  logic [31:0] f0, f1;
  logic [15:0] f16;
  logic [31:0] fo [3];
  logic        co [3];
  logic        ov [3];
  logic        zr [3];
  logic        bz [3];
  logic        dn [3];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   idle_at = 0;
  bit   mon_en = 0;
  bit   rst_prev = 0;
  exp_t sbq [3][$];
  exp_t held [3];
  int   NS [3] = '{8, 1, 4};
  int   WD [3] = '{32, 32, 16};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slice_serial_alu #(.WIDTH(32), .SLICE(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start_x[0]), .a(a_r), .b(b_r),
    .s(s_r), .c_in(cin_r), .f(f0), .cout(co[0]), .overflow(ov[0]),
    .zero(zr[0]), .busy(bz[0]), .done(dn[0])
  );

  slice_serial_alu #(.WIDTH(32), .SLICE(32)) u_s32 (
    .clk(clk), .rst(rst), .start(start_x[1]), .a(a_r), .b(b_r),
    .s(s_r), .c_in(cin_r), .f(f1), .cout(co[1]), .overflow(ov[1]),
    .zero(zr[1]), .busy(bz[1]), .done(dn[1])
  );

  slice_serial_alu #(.WIDTH(16), .SLICE(4)) u_w16 (
    .clk(clk), .rst(rst), .start(start_x[2]), .a(a_r[15:0]),
    .b(b_r[15:0]), .s(s_r), .c_in(cin_r), .f(f16), .cout(co[2]),
    .overflow(ov[2]), .zero(zr[2]), .busy(bz[2]), .done(dn[2])
  );

  assign fo[0] = f0;
  assign fo[1] = f1;
  assign fo[2] = {16'h0000, f16};

  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b,
                                 logic [2:0] s, logic cin);
    exp_t e;
    longint unsigned m, x, y, r, sum, sx, sy, sr;
    bit ar;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, a} & m;
    y = {32'd0, b} & m;
    r = 0;
    ar = 0;
    case (s)
      3'd0: r = 0;
      3'd1: begin x = ~x & m; ar = 1; end
      3'd2: begin y = ~y & m; ar = 1; end
      3'd3: ar = 1;
      3'd4: r = x ^ y;
      3'd5: r = x | y;
      3'd6: r = x & y;
      default: r = m;
    endcase
    e.cout = 1'b0;
    e.ovf = 1'b0;
    if (ar) begin
      sum = x + y + {63'd0, cin};
      r = sum & m;
      e.cout = ((sum >> w) & 64'd1) != 0;
      sx = (x >> (w - 1)) & 64'd1;
      sy = (y >> (w - 1)) & 64'd1;
      sr = (r >> (w - 1)) & 64'd1;
      e.ovf = (sx == sy) && (sr != sx);
    end
    e.f = r[31:0];
    e.zero = (r == 0);
    e.cyc = 0;
    return e;
  endfunction

  // Called at posedge+1 while every DUT is (per the model) idle or finishing.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] s, input logic cin,
                       input int gap);
    exp_t e;
    while (cyc < idle_at) begin
      @(posedge clk);
      #1;
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    a_r = a;
    b_r = b;
    s_r = s;
    cin_r = cin;
    start_x = 3'b111;
    for (int d = 0; d < 3; d++) begin
      e = model(WD[d], a, b, s, cin);
      e.cyc = cyc + 1 + NS[d];
      sbq[d].push_back(e);
    end
    idle_at = cyc + 1 + NS[0];
    @(posedge clk);
    #1;
    start_x = 3'b000;
    a_r = $urandom;
    b_r = $urandom;
    s_r = 3'($urandom_range(0, 7));
    cin_r = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit bexp;
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (rst_prev) begin
          held[d].f = '0;
          held[d].cout = 1'b0;
          held[d].ovf = 1'b0;
          held[d].zero = 1'b0;
        end
        bexp = (sbq[d].size() > 0) && (cyc >= sbq[d][0].cyc - NS[d])
               && (cyc < sbq[d][0].cyc);
        if (sbq[d].size() > 0 && cyc == sbq[d][0].cyc) begin
          e = sbq[d].pop_front();
          checks++;
          if (dn[d] !== 1'b1 || fo[d] !== e.f || co[d] !== e.cout ||
              ov[d] !== e.ovf || zr[d] !== e.zero) begin
            errors++;
            $display("FAIL result dut%0d cyc %0d: got done=%b f=%h c=%b v=%b z=%b, want done=1 f=%h c=%b v=%b z=%b",
                     d, cyc, dn[d], fo[d], co[d], ov[d], zr[d],
                     e.f, e.cout, e.ovf, e.zero);
          end
          held[d] = e;
        end else begin
          checks++;
          if (dn[d] !== 1'b0) begin
            errors++;
            $display("FAIL stray_done dut%0d cyc %0d: got done=%b, want 0",
                     d, cyc, dn[d]);
          end
          checks++;
          if (fo[d] !== held[d].f || co[d] !== held[d].cout ||
              ov[d] !== held[d].ovf || zr[d] !== held[d].zero) begin
            errors++;
            $display("FAIL hold dut%0d cyc %0d: got f=%h c=%b v=%b z=%b, want f=%h c=%b v=%b z=%b",
                     d, cyc, fo[d], co[d], ov[d], zr[d], held[d].f,
                     held[d].cout, held[d].ovf, held[d].zero);
          end
        end
        checks++;
        if (bz[d] !== bexp) begin
          errors++;
          $display("FAIL busy dut%0d cyc %0d: got %b, want %b",
                   d, cyc, bz[d], bexp);
        end
      end
    end
    rst_prev = rst;
  end

  initial begin
    int acc;
    for (int d = 0; d < 3; d++) begin
      held[d].f = '0;
      held[d].cout = 1'b0;
      held[d].ovf = 1'b0;
      held[d].zero = 1'b0;
      held[d].cyc = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;
    idle_at = cyc;

    issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b011, 1'b0, 2);
    issue(32'h8000_0000, 32'h0000_0001, 3'b010, 1'b1, 1);
    issue(32'h0000_0005, 32'h0000_0003, 3'b001, 1'b1, 1);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 3'b011, 1'b0, 1);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b110, 1'b1, 1);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101, 1'b0, 1);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 1'b1, 1);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111, 1'b0, 1);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b1, 1);

    issue(32'h1234_5678, 32'h0FED_CBA9, 3'b011, 1'b1, 0);
    issue(32'hDEAD_BEEF, 32'h0000_FFFF, 3'b010, 1'b0, 0);

    issue(32'h0000_00AA, 32'h0000_0055, 3'b011, 1'b0, 1);
    acc = cyc;
    while (cyc < acc + 2) begin
      @(posedge clk);
      #1;
    end
    a_r = 32'hFFFF_0000;
    b_r = 32'h0000_FFFF;
    s_r = 3'b111;
    start_x = 3'b001;
    @(posedge clk);
    #1;
    start_x = 3'b000;

    issue(32'h0F0F_0F0F, 32'h0101_0101, 3'b011, 1'b1, 1);
    acc = cyc;
    while (cyc < acc + 3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) sbq[d].delete();
    idle_at = cyc;

    for (int i = 0; i < 60; i++) begin
      issue(pick(), pick(), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    while (cyc < idle_at + 3) begin
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (sbq[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d pending, want 0",
                 d, sbq[d].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_serial_alu.md
Name: slice_serial_alu

Overview:
- Parametrised, multi-cycle successor to the 32-bit 74381-style ripple ALU.
- Computes one WIDTH-bit 74381 function by iterating a single SLICE-bit slice LSB-first, one slice per clock.
- The slice-to-slice carry is held in a register between cycles.
- Adds a start/done handshake, busy status and a zero flag; sits in the datapath where area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width; must be a positive multiple of SLICE.
- SLICE, 4, bits processed per cycle. NSLICE = WIDTH/SLICE is the latency in cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted on a rising edge when busy=0.
- a  input  WIDTH  operand A, sampled at accept.
- b  input  WIDTH  operand B, sampled at accept.
- s  input  3  function select, sampled at accept.
- c_in  input  1  carry-in to slice 0, sampled at accept.
- f  output  WIDTH  result.
- cout  output  1  carry out of the MSB slice.
- overflow  output  1  signed overflow.
- zero  output  1  f == 0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle result-valid pulse.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; f=0, cout=0, overflow=0, zero=0, busy=0, done=0; internal operand, carry and slice-index registers cleared. Reset wins over every other input, including mid-operation; the aborted operation never raises done.
- Function table for s, with all arithmetic on latched operands:
  - 000: F=0
  - 001: B minus A = B + ~A + c_in
  - 010: A minus B = A + ~B + c_in
  - 011: A plus B = A + B + c_in
  - 100: A xor B
  - 101: A or B
  - 110: A and B
  - 111: F = all ones
- States: IDLE, RUN.
  - IDLE: busy=0. At an edge with start=1: latch a, b, s and c_in; set carry=c_in and index=0; go to RUN.
  - RUN: busy=1. At edge k (k=1..NSLICE after accept), compute slice index k-1 (bits (k-1)*SLICE upward) from the latched operands and registered carry. Write that slice into the internal result register and update carry with the slice carry-out.
  - On the edge that computes slice NSLICE-1:
    - f := full result.
    - cout := final carry for ops 001/010/011, else 0.
    - overflow := carry into MSB xor carry out of MSB for ops 001/010/011, else 0.
    - zero := (result == 0).
    - done := 1 for exactly one cycle; busy := 0; return to IDLE.
- Latency: done is high in the cycle following the NSLICE-th edge after accept. With SLICE=WIDTH, done is high the cycle after accept.
- f, cout, overflow and zero change only at the completing edge or at reset. They hold between operations and do not show partial results.
- start while busy=1 is ignored (not queued). Operand or s changes during RUN have no effect.
- Back-to-back: start=1 during the done cycle is accepted, since busy=0 in that cycle.
- Carry-in is honoured for all arithmetic ops. Logic and constant ops ignore c_in and the carry chain.

Test Plan:
- WIDTH=32, SLICE=4: s=011, a=0xFFFFFFFF, b=0x00000001, c_in=0 -> done exactly 8 cycles after accept; f=0x00000000, cout=1, overflow=0, zero=1; busy high for those 8 cycles only.
- s=010, a=0x80000000, b=0x00000001, c_in=1 -> f=0x7FFFFFFF, cout=1, overflow=1, zero=0.
- s=001, a=5, b=3, c_in=1 -> f=0xFFFFFFFE, cout=0, overflow=0; s=011, a=0x7FFFFFFF, b=1, c_in=0 -> f=0x80000000, overflow=1, cout=0.
- Logic ops on a=0xF0F0F0F0, b=0xFF00FF00:
  - s=110 -> f=0xF000F000
  - s=101 -> f=0xFFF0FFF0
  - s=100 -> f=0x0FF00FF0
  - s=111 -> f=0xFFFFFFFF
  - s=000 -> f=0, zero=1
  - cout=overflow=0 throughout.
- Robustness:
  - Pulse start again at cycle 3 of a run with different operands -> ignored; first result is unchanged.
  - Assert rst at cycle 4 of a run -> next cycle busy=0 and f=0; no done pulse.
- Back-to-back and parameter variants:
  - start held during the done cycle -> second op accepted; its done follows 8 cycles later.
  - Rebuild with SLICE=32 -> done the cycle after accept with identical results.
  - Rebuild with WIDTH=16, SLICE=4: s=011, 0xFFFF+0x0001 -> f=0x0000, cout=1, latency 4.
